// File: rtl/vm2002_change_dispenser.sv
// rtl/vm2002_change_dispenser.sv - greedy quarter/dime/nickel change payout with tube refill
// Optional eject-handshake watchdog enabled by defining VM_CHG_TIMEOUT_EN.
module vm2002_change_dispenser #(
  parameter int TUBE_MAX       = 15,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic        clk,
  input  logic        hrst,
  input  logic        change_req,
  input  logic [15:0] change_amt,
  output logic        change_ack,
  output logic [1:0]  coin_out,
  output logic        coin_valid,
  input  logic        coin_taken,
  output logic        done,
  output logic        short,
  output logic [15:0] residue,
  output logic        busy,
  input  logic        refill_valid,
  input  logic [1:0]  refill_coin,
  input  logic [3:0]  refill_count,
  output logic        refill_err,
  output logic [3:0]  q_level,
  output logic [3:0]  d_level,
  output logic [3:0]  n_level
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  state_t      state, state_nx;
  logic [15:0] rem;
  logic [1:0]  pick;
  logic        take;
  logic        timeout;
  logic [3:0]  refill_level;
  logic [4:0]  refill_sum;
  logic        refill_ovf;
  logic [3:0]  refill_new;
  logic        refill_go;

  function automatic logic [15:0] coin_value(input logic [1:0] c);
    case (c)
      2'b11:   coin_value = 16'd25;
      2'b10:   coin_value = 16'd10;
      2'b01:   coin_value = 16'd5;
      default: coin_value = 16'd0;
    endcase
  endfunction

  // Greedy pick: largest coin that fits the remaining balance and is in stock.
  always_comb begin
    pick = 2'b00;
    if (rem >= 16'd25 && q_level != 4'd0)      pick = 2'b11;
    else if (rem >= 16'd10 && d_level != 4'd0) pick = 2'b10;
    else if (rem >= 16'd5 && n_level != 4'd0)  pick = 2'b01;
  end

  assign take = (state == ISSUE) && coin_valid && coin_taken;
  assign busy = (state != IDLE);

`ifdef VM_CHG_TIMEOUT_EN
  logic [9:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (hrst || state != ISSUE) wd_cnt <= 10'd0;
    else                        wd_cnt <= wd_cnt + 10'd1;
  end

  assign timeout = (state == ISSUE) && !coin_taken && (wd_cnt == 10'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    refill_level = 4'd0;
    case (refill_coin)
      2'b11:   refill_level = q_level;
      2'b10:   refill_level = d_level;
      2'b01:   refill_level = n_level;
      default: refill_level = 4'd0;
    endcase
    refill_sum = {1'b0, refill_level} + {1'b0, refill_count};
    refill_ovf = (refill_sum > 5'(TUBE_MAX));
    refill_new = refill_ovf ? 4'(TUBE_MAX) : refill_sum[3:0];
    refill_go  = (state == IDLE) && !change_req && refill_valid &&
                 (refill_coin != 2'b00) && (refill_count != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (hrst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (change_req) state_nx = SELECT;
      SELECT:  state_nx = (pick != 2'b00) ? ISSUE : FINISH;
      ISSUE: begin
        if (take)         state_nx = SELECT;
        else if (timeout) state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hrst) begin
      rem        <= 16'd0;
      change_ack <= 1'b0;
      coin_out   <= 2'b00;
      coin_valid <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      residue    <= 16'd0;
      refill_err <= 1'b0;
      q_level    <= 4'd0;
      d_level    <= 4'd0;
      n_level    <= 4'd0;
    end else begin
      change_ack <= 1'b0;
      done       <= 1'b0;
      short      <= 1'b0;
      refill_err <= 1'b0;
      case (state)
        IDLE: begin
          if (change_req) begin
            rem        <= change_amt;
            change_ack <= 1'b1;
          end else if (refill_go) begin
            refill_err <= refill_ovf;
            case (refill_coin)
              2'b11:   q_level <= refill_new;
              2'b10:   d_level <= refill_new;
              default: n_level <= refill_new;
            endcase
          end
        end
        SELECT: begin
          if (pick != 2'b00) begin
            coin_out   <= pick;
            coin_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (take) begin
            coin_valid <= 1'b0;
            coin_out   <= 2'b00;
            rem        <= rem - coin_value(coin_out);
            case (coin_out)
              2'b11:   q_level <= q_level - 4'd1;
              2'b10:   d_level <= d_level - 4'd1;
              default: n_level <= n_level - 4'd1;
            endcase
          end else if (timeout) begin
            // Abandoned coin is never deducted: rem and levels stay as they are.
            coin_valid <= 1'b0;
            coin_out   <= 2'b00;
          end
        end
        FINISH: begin
          done    <= (rem == 16'd0);
          short   <= (rem != 16'd0);
          residue <= rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb/tb_vm2002_change_dispenser.sv - scoreboard bench for vm2002_change_dispenser
module tb_vm2002_change_dispenser;

  logic        clk = 1'b0;
  logic        hrst = 1'b0;
  logic        change_req = 1'b0;
  logic [15:0] change_amt = 16'd0;
  logic        change_ack;
  logic [1:0]  coin_out;
  logic        coin_valid;
  logic        coin_taken = 1'b0;
  logic        done;
  logic        short;
  logic [15:0] residue;
  logic        busy;
  logic        refill_valid = 1'b0;
  logic [1:0]  refill_coin = 2'b00;
  logic [3:0]  refill_count = 4'd0;
  logic        refill_err;
  logic [3:0]  q_level, d_level, n_level;

  int checks = 0;
  int errors = 0;
  logic [1:0]  exp_coin[$];
  logic [17:0] exp_end[$];
  logic        auto_take = 1'b1;
  logic        cv_prev = 1'b0;
  logic        mon_cv_prev = 1'b0;
  logic        err_s;

  vm2002_change_dispenser dut (
    .clk(clk), .hrst(hrst), .change_req(change_req), .change_amt(change_amt),
    .change_ack(change_ack), .coin_out(coin_out), .coin_valid(coin_valid),
    .coin_taken(coin_taken), .done(done), .short(short), .residue(residue),
    .busy(busy), .refill_valid(refill_valid), .refill_coin(refill_coin),
    .refill_count(refill_count), .refill_err(refill_err),
    .q_level(q_level), .d_level(d_level), .n_level(n_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Eject mechanism: takes each coin one cycle after it is first presented.
  always @(negedge clk) begin
    coin_taken = auto_take && coin_valid && cv_prev && !coin_taken;
    cv_prev = coin_valid;
  end

  always @(negedge clk) begin
    if (coin_valid && !mon_cv_prev) begin
      if (exp_coin.size() == 0) begin
        checks++; errors++;
        $display("FAIL coin_unexpected: got %0h expected none", coin_out);
      end else check("coin", 32'(coin_out), 32'(exp_coin.pop_front()));
    end
    mon_cv_prev = coin_valid;
    if (done || short) begin
      if (exp_end.size() == 0) begin
        checks++; errors++;
        $display("FAIL end_unexpected: got %0h expected none", {done, short, residue});
      end else check("end", 32'({done, short, residue}), 32'(exp_end.pop_front()));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    hrst = 1'b1;
    repeat (2) tick();
    hrst = 1'b0;
  endtask

  task automatic refill(input logic [1:0] c, input logic [3:0] n, output logic err);
    refill_valid = 1'b1; refill_coin = c; refill_count = n;
    tick();
    refill_valid = 1'b0; refill_coin = 2'b00; refill_count = 4'd0;
    err = refill_err;
  endtask

  task automatic request(input logic [15:0] amt);
    change_req = 1'b1; change_amt = amt;
    tick();
    change_req = 1'b0;
    check("ack", 32'(change_ack), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check("idle", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic wait_cv(input logic val);
    int n = 0;
    while (coin_valid !== val && n < 100) begin tick(); n++; end
    check("cv_wait", 32'(coin_valid), 32'(val));
  endtask

  initial begin
    tick();
    do_reset();
    check("rst_outs", 32'({change_ack, coin_out, coin_valid, done, short, busy, refill_err}), 32'd0);
    check("rst_residue", 32'(residue), 32'd0);
    check("rst_levels", 32'({q_level, d_level, n_level}), 32'h000);

    refill(2'b11, 4'd4, err_s);
    refill(2'b10, 4'd4, err_s);
    refill(2'b01, 4'd4, err_s);
    check("fill_err", 32'(err_s), 32'd0);
    check("fill_levels", 32'({q_level, d_level, n_level}), 32'h444);
    exp_coin.push_back(2'b11); exp_coin.push_back(2'b10); exp_coin.push_back(2'b01);
    exp_end.push_back({2'b10, 16'd0});
    request(16'd40);
    wait_idle(200);
    check("lv_40", 32'({q_level, d_level, n_level}), 32'h333);

    do_reset();
    refill(2'b10, 4'd2, err_s);
    refill(2'b01, 4'd2, err_s);
    check("lv_022", 32'({q_level, d_level, n_level}), 32'h022);
    exp_coin.push_back(2'b10); exp_coin.push_back(2'b10);
    exp_coin.push_back(2'b01); exp_coin.push_back(2'b01);
    exp_end.push_back({2'b10, 16'd0});
    request(16'd30);
    wait_idle(200);
    check("lv_30", 32'({q_level, d_level, n_level}), 32'h000);

    refill(2'b11, 4'd1, err_s);
    exp_coin.push_back(2'b11);
    exp_end.push_back({2'b01, 16'd10});
    request(16'd35);
    wait_idle(200);
    check("lv_35", 32'({q_level, d_level, n_level}), 32'h000);

    refill(2'b01, 4'd12, err_s);
    check("err_12", 32'(err_s), 32'd0);
    refill(2'b01, 4'd5, err_s);
    check("err_ovf", 32'(err_s), 32'd1);
    check("n_sat", 32'(n_level), 32'd15);
    tick();
    check("err_once", 32'(refill_err), 32'd0);

    refill(2'b00, 4'd5, err_s);
    check("noop_err", 32'(err_s), 32'd0);
    check("noop_lv", 32'({q_level, d_level, n_level}), 32'h00F);

    exp_coin.push_back(2'b01);
    exp_end.push_back({2'b01, 16'd2});
    request(16'd7);
    wait_idle(200);
    check("n_7", 32'(n_level), 32'd14);

    // Zero-amount request racing a refill: request wins, done 3 cycles later.
    exp_end.push_back({2'b10, 16'd0});
    refill_valid = 1'b1; refill_coin = 2'b11; refill_count = 4'd5;
    request(16'd0);
    refill_valid = 1'b0; refill_coin = 2'b00; refill_count = 4'd0;
    tick();
    check("zero_mid", 32'({done, busy}), 32'b01);
    tick();
    check("zero_done", 32'({done, busy}), 32'b10);
    check("zero_q", 32'(q_level), 32'd0);
    tick();

    auto_take = 1'b0;
    exp_coin.push_back(2'b01);
    exp_end.push_back({2'b10, 16'd0});
    request(16'd5);
    wait_cv(1'b1);
    refill(2'b11, 4'd3, err_s);
    check("issue_refill_q", 32'(q_level), 32'd0);
    check("issue_refill_err", 32'(err_s), 32'd0);
    auto_take = 1'b1;
    wait_idle(200);
    check("n_5", 32'(n_level), 32'd13);

    do_reset();
    refill(2'b11, 4'd2, err_s);
    exp_coin.push_back(2'b11); exp_coin.push_back(2'b11);
    request(16'd50);
    wait_cv(1'b1);
    wait_cv(1'b0);
    wait_cv(1'b1);
    hrst = 1'b1;
    tick();
    hrst = 1'b0;
    check("abort_outs", 32'({coin_valid, busy, done, short}), 32'd0);
    check("abort_lv", 32'({q_level, d_level, n_level}), 32'h000);
    tick();

`ifdef VM_CHG_TIMEOUT_EN
    refill(2'b11, 4'd2, err_s);
    auto_take = 1'b0;
    exp_coin.push_back(2'b11);
    exp_end.push_back({2'b01, 16'd50});
    request(16'd50);
    wait_idle(2000);
    check("to_q", 32'(q_level), 32'd2);
    check("to_cv", 32'(coin_valid), 32'd0);
    auto_take = 1'b1;
`endif

    repeat (2) tick();
    check("queues_empty", 32'(exp_coin.size() + exp_end.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
